display_capture: RTL and testbench
==================================

# display_capture

Receive-side counterpart of the multiplexed seven-segment driver: oversamples the scanned nibble/select/dot bus and rebuilds the full digit frame. Sits on the self-check path, on the board side or in the bench. Each complete, consistent scan publishes all digit values and dots at once with a one-cycle strobe. Malformed or blanked scans are flagged.

## Interface
Parameters:
- NUM_DIGITS, 4, digits per frame (1..8); select lines `sm_wei[NUM_DIGITS-1:0]` are used.
- STABLE_CYCLES, 3, consecutive identical samples required before a select/nibble is accepted (2..15).
- BLANK_TIMEOUT, 64, consecutive all-inactive samples that declare the display blanked (2..1023).

Ports:
- clk  in  1  sampling clock; at least 4x STABLE_CYCLES faster than the scan clock.
- rst  in  1  synchronous, active-high reset.
- sm_duan  in  4  scanned digit nibble, bit 0 = LSB.
- sm_dot  in  1  scanned decimal point for the current digit, active-high.
- sm_wei  in  8  digit select, active-low one-hot; bit k low selects digit k.
- data_out  out  4*NUM_DIGITS  captured frame; digit k occupies bits [4k+3:4k].
- dots_out  out  NUM_DIGITS  captured dots; bit k belongs to digit k.
- frame_valid  out  1  one-cycle pulse when data_out/dots_out update.
- frame_err  out  1  one-cycle pulse on a malformed select.
- blank  out  1  level; high while the display is considered blanked.

## Operation
- Sample vector: {sm_wei, sm_dot, sm_duan}.
- Stability counter:
  - Increments while the sample equals the previous sample; reloads to 1 on any change.
  - Saturates at STABLE_CYCLES.
  - A sample is "accepted" exactly once, on the cycle the counter reaches STABLE_CYCLES.
- Classification of an accepted sample:
  - DIGIT k: exactly one of `sm_wei[NUM_DIGITS-1:0]` is low, and all of `sm_wei[7:NUM_DIGITS]` are high.
  - IDLE_SEL: all 8 lines are high.
  - BAD: anything else.
- FSM states:
  - SYNC, reset state: waits for accepted DIGIT 0. On DIGIT 0, store shadow[0], set seen = 1, go to COLLECT.
  - COLLECT:
    - DIGIT k with k > 0: store shadow[k] and set seen[k]. A repeat of an already-seen k overwrites it.
    - DIGIT 0 with seen all ones: copy shadow to data_out/dots_out, pulse frame_valid, set seen = 1 (digit 0 stored), stay in COLLECT.
    - DIGIT 0 with seen incomplete: restart; seen = 1, shadow[0] reloaded, no strobe.
  - BLANKED:
    - blank = 1.
    - On accepted DIGIT 0: blank = 0, store shadow[0], go to COLLECT.
    - Any other DIGIT: go to SYNC.
- Independent of state:
  - BAD accepted: pulse frame_err, clear seen, go to SYNC.
  - All-high raw samples for BLANK_TIMEOUT consecutive cycles, counted on raw samples and not on accepted ones: go to BLANKED, clear seen. data_out/dots_out hold their last values.
  - IDLE_SEL shorter than BLANK_TIMEOUT (inter-digit ghosting gap) is ignored.

## Timing
- Reset values: data_out 0, dots_out 0, frame_valid 0, frame_err 0, blank 0, seen 0, counters 0, state SYNC.
- Latency, sync enabled: input change to acceptance = 2 (synchronizer) + STABLE_CYCLES clocks. frame_valid/data_out update on the clock after the accepted DIGIT 0.
- frame_valid and frame_err never assert in the same cycle. On a single accepted sample only one classification applies.
- Blank timeout and acceptance in the same cycle: blank takes priority.
- rst mid-frame: next cycle is in SYNC with all outputs at reset values. Partial shadow contents are discarded.
- Counter widths: stability 4 bits; blank 10 bits, saturating.

## Configuration
- DISPLAY_CAPTURE_SYNC_EN defined: all 13 input bits pass through a 2-flop synchronizer before the stability filter; latency as stated above.
- DISPLAY_CAPTURE_SYNC_EN undefined: inputs feed the filter directly; every latency figure above drops by 2 clocks. For same-clock bench use only.

## Test plan
- Scan digits 0..3 with nibbles 6, 2, 9, 8 and dots 1, 1, 1, 0, each held 10 clocks; repeat the scan twice. Required: frame_valid pulses once per wrap to digit 0; data_out = 16'h8926; dots_out = 4'b0111.
- Glitch: digit 2 nibble shows 4'hF for 2 clocks before 9, with STABLE_CYCLES = 3. Required: data_out = 16'h8926; no frame_err.
- Drive sm_wei = 8'b1111_1100 stably mid-scan. Required: one frame_err pulse, no frame_valid on the next digit-0 wrap; data_out = 16'h8926 again after one clean full scan.
- Hold sm_wei = 8'hFF for 64 clocks. Required: blank = 1 from cycle 64 (+2 if sync enabled), data_out unchanged. Resume scanning: blank = 0 on accepted digit 0; the next full scan strobes.
- Assert rst during digit 2 of the first scan. Required: all outputs 0 on the next cycle; the first frame_valid only after a complete 0..3 scan followed by digit 0.
- Scan 0, 1, 0, 1, 2, 3, 0 (skipping ahead). Required: no strobe on the first digit-0 repeat; exactly one strobe on the final digit 0.

Source files
------------

// File: rtl/display_capture_if.sv
// Scanned seven-segment bus plus the rebuilt frame outputs of display_capture.
interface display_capture_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [3:0]              sm_duan;
  logic                    sm_dot;
  logic [7:0]              sm_wei;
  logic [4*NUM_DIGITS-1:0] data_out;
  logic [NUM_DIGITS-1:0]   dots_out;
  logic                    frame_valid;
  logic                    frame_err;
  logic                    blank;

  modport master (
    output sm_duan, sm_dot, sm_wei,
    input  data_out, dots_out, frame_valid, frame_err, blank
  );

  modport slave (
    input  sm_duan, sm_dot, sm_wei,
    output data_out, dots_out, frame_valid, frame_err, blank
  );
endinterface

// File: rtl/display_capture.sv
// Oversamples a multiplexed seven-segment scan and rebuilds the digit frame.
// Optional input synchronizer: define DISPLAY_CAPTURE_SYNC_EN.
module display_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned BLANK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  display_capture_if.slave bus
);
  localparam int unsigned SAMP_W = 13;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam logic [7:0]            UPPER_MASK = 8'(8'hFF << NUM_DIGITS);
  localparam logic [SAMP_W-1:0]     IDLE_SAMP  = {8'hFF, 5'h00};
  localparam logic [3:0]            STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [9:0]            BLANK_MAX  = 10'(BLANK_TIMEOUT);
  localparam logic [NUM_DIGITS-1:0] SEEN_ALL   = '1;
  localparam logic [NUM_DIGITS-1:0] SEEN_FIRST = NUM_DIGITS'(1);

  typedef enum logic [1:0] {SYNC, COLLECT, BLANKED} state_t;

  state_t                  state, state_nxt;
  logic [SAMP_W-1:0]       raw, samp, samp_prev;
  logic [3:0]              stab_cnt, stab_nxt;
  logic [9:0]              blank_cnt, blank_cnt_nxt;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [DATA_W-1:0]       shadow_data, shadow_data_nxt, data_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dots, shadow_dots_nxt, dots_nxt;
  logic                    frame_valid_nxt, frame_err_nxt, store_en;
  logic [7:0]              samp_wei, low_sel;
  logic                    samp_dot;
  logic [3:0]              samp_nib;
  logic                    same, accept, idle_raw, blank_trig;
  logic                    is_digit, is_bad;
  logic [NUM_DIGITS-1:0]   dig_oh;

  assign raw = {bus.sm_wei, bus.sm_dot, bus.sm_duan};

`ifdef DISPLAY_CAPTURE_SYNC_EN
  logic [SAMP_W-1:0] sync_q1, sync_q2;

  // Two-flop synchronizer; resets to an all-inactive select so no false BAD
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= IDLE_SAMP;
      sync_q2 <= IDLE_SAMP;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end
  assign samp = sync_q2;
`else
  assign samp = raw;
`endif

  assign samp_wei = samp[12:5];
  assign samp_dot = samp[4];
  assign samp_nib = samp[3:0];

  // Stability filter: accept fires once, on the cycle the count reaches STABLE_CYCLES
  assign same     = (samp == samp_prev);
  assign stab_nxt = !same ? 4'd1 :
                    (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + 4'd1;
  assign accept   = same && (stab_cnt == STABLE_MAX - 4'd1);

  // Blank detection runs on raw samples, independent of the filter
  assign idle_raw      = (samp_wei == 8'hFF);
  assign blank_cnt_nxt = !idle_raw ? 10'd0 :
                         (blank_cnt == 10'h3FF) ? blank_cnt : blank_cnt + 10'd1;
  assign blank_trig    = idle_raw && (blank_cnt == BLANK_MAX - 10'd1);

  assign low_sel  = ~samp_wei & ~UPPER_MASK;
  assign is_digit = ((samp_wei & UPPER_MASK) == UPPER_MASK) && $onehot(low_sel);
  assign is_bad   = !is_digit && !idle_raw;
  assign dig_oh   = low_sel[NUM_DIGITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SYNC;
      samp_prev       <= IDLE_SAMP;
      stab_cnt        <= '0;
      blank_cnt       <= '0;
      seen            <= '0;
      shadow_data     <= '0;
      shadow_dots     <= '0;
      bus.data_out    <= '0;
      bus.dots_out    <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.blank       <= 1'b0;
    end else begin
      state           <= state_nxt;
      samp_prev       <= samp;
      stab_cnt        <= stab_nxt;
      blank_cnt       <= blank_cnt_nxt;
      seen            <= seen_nxt;
      shadow_data     <= shadow_data_nxt;
      shadow_dots     <= shadow_dots_nxt;
      bus.data_out    <= data_nxt;
      bus.dots_out    <= dots_nxt;
      bus.frame_valid <= frame_valid_nxt;
      bus.frame_err   <= frame_err_nxt;
      bus.blank       <= (state_nxt == BLANKED);
    end
  end

  // Frame FSM; blank timeout outranks any acceptance in the same cycle
  always_comb begin
    state_nxt       = state;
    seen_nxt        = seen;
    shadow_data_nxt = shadow_data;
    shadow_dots_nxt = shadow_dots;
    data_nxt        = bus.data_out;
    dots_nxt        = bus.dots_out;
    frame_valid_nxt = 1'b0;
    frame_err_nxt   = 1'b0;
    store_en        = 1'b0;

    if (blank_trig) begin
      state_nxt = BLANKED;
      seen_nxt  = '0;
    end else if (accept && is_bad) begin
      frame_err_nxt = 1'b1;
      seen_nxt      = '0;
      state_nxt     = SYNC;
    end else if (accept && is_digit) begin
      case (state)
        SYNC: begin
          if (dig_oh[0]) begin
            store_en  = 1'b1;
            seen_nxt  = SEEN_FIRST;
            state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          store_en = 1'b1;
          if (dig_oh[0]) begin
            // Wrap to digit 0 publishes the frame only if every digit was seen
            if (seen == SEEN_ALL) begin
              data_nxt        = shadow_data;
              dots_nxt        = shadow_dots;
              frame_valid_nxt = 1'b1;
            end
            seen_nxt = SEEN_FIRST;
          end else begin
            seen_nxt = seen | dig_oh;
          end
        end
        BLANKED: begin
          if (dig_oh[0]) begin
            store_en  = 1'b1;
            seen_nxt  = SEEN_FIRST;
            state_nxt = COLLECT;
          end else begin
            state_nxt = SYNC;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end

    if (store_en) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (dig_oh[i]) begin
          shadow_data_nxt[4*i +: 4] = samp_nib;
          shadow_dots_nxt[i]        = samp_dot;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus queues expected frames, a monitor checks strobes.
module tb_display_capture;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dots;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_capture_if #(.NUM_DIGITS(4)) bus ();

  display_capture #(
    .NUM_DIGITS   (4),
    .STABLE_CYCLES(3),
    .BLANK_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   err_pending = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] wei_of(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  task automatic drive(input logic [7:0] wei, input logic [3:0] nib, input logic dot, input int n);
    bus.sm_wei  = wei;
    bus.sm_duan = nib;
    bus.sm_dot  = dot;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int k, input logic [3:0] nib, input logic dot, input int n);
    drive(wei_of(k), nib, dot, n);
  endtask

  task automatic scan(input logic [15:0] nibs, input logic [3:0] dts);
    for (int k = 0; k < 4; k++) digit(k, nibs[4*k +: 4], dts[k], 10);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    e.data = d;
    e.dots = p;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"},    32'(bus.data_out), 32'h0);
    check({tag, "_dots_out"},    32'(bus.dots_out), 32'h0);
    check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'h0);
    check({tag, "_frame_err"},   32'(bus.frame_err), 32'h0);
    check({tag, "_blank"},       32'(bus.blank), 32'h0);
  endtask

  // Monitor: every strobe must match the oldest expected frame
  always @(negedge clk) begin
    if (bus.frame_valid || bus.frame_err)
      check("fv_fe_exclusive", 32'(bus.frame_valid & bus.frame_err), 32'h0);
    if (bus.frame_valid) begin
      check("frame_valid_expected", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_data_out", 32'(bus.data_out), 32'(e.data));
        check("frame_dots_out", 32'(bus.dots_out), 32'(e.dots));
      end
    end
    if (bus.frame_err) begin
      check("frame_err_expected", 32'(err_pending > 0), 32'h1);
      if (err_pending > 0) err_pending--;
    end
  end

  initial begin
    rst = 1'b1;
    bus.sm_wei  = 8'hFF;
    bus.sm_duan = 4'h0;
    bus.sm_dot  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    drive(8'hFF, 4'h0, 1'b0, 4);

    // Two clean scans and a final wrap: one strobe per wrap
    scan(16'h8926, 4'b0111);
    push(16'h8926, 4'b0111);
    scan(16'h8926, 4'b0111);
    push(16'h8926, 4'b0111);
    digit(0, 4'h6, 1'b1, 10);

    // Two-clock glitch on digit 2 must be filtered out
    digit(1, 4'h2, 1'b1, 10);
    digit(2, 4'hF, 1'b1, 2);
    digit(2, 4'h9, 1'b1, 10);
    digit(3, 4'h8, 1'b0, 10);
    push(16'h8926, 4'b0111);
    digit(0, 4'h6, 1'b1, 10);

    // Malformed select: error, then a resync and one clean scan before a strobe
    digit(1, 4'h2, 1'b1, 10);
    err_pending++;
    drive(8'hFC, 4'h5, 1'b0, 10);
    digit(2, 4'hA, 1'b0, 10);
    digit(3, 4'hB, 1'b0, 10);
    digit(0, 4'h6, 1'b1, 10);
    digit(1, 4'h2, 1'b1, 10);
    digit(2, 4'h9, 1'b1, 10);
    digit(3, 4'h8, 1'b0, 10);
    push(16'h8926, 4'b0111);
    digit(0, 4'h6, 1'b1, 10);

    // Blank timeout on raw all-inactive samples
    bus.sm_wei = 8'hFF;
    repeat (63) @(posedge clk);
    #1;
    check("blank_before_timeout", 32'(bus.blank), 32'h0);
    @(posedge clk);
    #1;
    check("blank_at_timeout", 32'(bus.blank), 32'h1);
    check("blank_data_hold", 32'(bus.data_out), 32'h8926);
    check("blank_dots_hold", 32'(bus.dots_out), 32'h7);
    drive(8'hFF, 4'h0, 1'b0, 6);
    check("blank_level_held", 32'(bus.blank), 32'h1);
    digit(0, 4'h5, 1'b0, 10);
    check("blank_cleared_by_digit0", 32'(bus.blank), 32'h0);
    digit(1, 4'h4, 1'b1, 10);
    digit(2, 4'h3, 1'b0, 10);
    digit(3, 4'h2, 1'b1, 10);
    push(16'h2345, 4'b1010);
    digit(0, 4'h6, 1'b1, 10);

    // Reset during digit 2 discards the partial frame
    digit(1, 4'h2, 1'b1, 10);
    digit(2, 4'h9, 1'b1, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    digit(2, 4'h9, 1'b1, 5);
    digit(3, 4'h8, 1'b0, 10);
    digit(0, 4'h6, 1'b1, 10);
    digit(1, 4'h2, 1'b1, 10);
    digit(2, 4'h9, 1'b1, 10);
    digit(3, 4'h8, 1'b0, 10);
    push(16'h8926, 4'b0111);
    digit(0, 4'h6, 1'b1, 10);

    // Early wrap restarts collection: only the last digit 0 strobes
    digit(0, 4'hA, 1'b0, 10);
    digit(1, 4'hB, 1'b1, 10);
    digit(0, 4'hC, 1'b1, 10);
    digit(1, 4'hD, 1'b0, 10);
    digit(2, 4'hE, 1'b1, 10);
    digit(3, 4'h1, 1'b0, 10);
    push(16'h1EDC, 4'b0101);
    digit(0, 4'h7, 1'b0, 10);

    drive(8'hFF, 4'h0, 1'b0, 10);
    check("strobes_outstanding", 32'(exp_q.size()), 32'h0);
    check("errors_outstanding", 32'(err_pending), 32'h0);
    check("final_data_out", 32'(bus.data_out), 32'h1EDC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
